uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter; counterpart to the uart_rx receiver on the same serial link.
- Control logic pushes bytes into an internal DEPTH-entry FIFO without waiting per byte.
- The block drains the FIFO back-to-back onto tx using the same Baud_Set encoding as uart_rx.
- Replaces per-byte send_en/tx_done polling in BRAM dump paths.

Parameters:
CLK_FREQ, 50_000_000, clk frequency in Hz; sets bit period DIV = CLK_FREQ / baud (integer floor).
DEPTH, 16, FIFO entries; power of two, minimum 2.
ADDR_W, 4, log2(DEPTH).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous reset, active-low.
Baud_Set  input  3  0:9600 1:19200 2:38400 3:57600 4:115200; values 5-7 select 115200.
wr_en  input  1  push wr_data this cycle.
wr_data  input  8  byte to transmit.
full  output  1  FIFO holds DEPTH entries.
empty  output  1  FIFO holds 0 entries.
level  output  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
overflow  output  1  one-cycle pulse when a push is dropped because the FIFO is full.
tx  output  1  serial line, idle high.
tx_busy  output  1  high from the first start-bit cycle through the last stop-bit cycle.
tx_done  output  1  one-cycle pulse in the last stop-bit cycle of each frame.

Behaviour:
- Reset (rst_n low at a clk edge): tx=1, tx_busy=0, tx_done=0, overflow=0, full=0, empty=1, level=0. FIFO pointers and FSM are cleared.
- Reset mid-frame: the frame is aborted, tx returns high on the next edge, and FIFO contents are discarded.
- FIFO write:
  - wr_en with full=0 stores the byte at the write pointer; level increments.
  - wr_en with full=1: the byte is dropped and overflow pulses.
  - Exception: if a pop occurs in the same cycle, the write is accepted (level unchanged) and there is no overflow.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. When empty=0: pop the head byte into the shift register, latch Baud_Set into the baud register, and go to START.
  - START: tx=0 for DIV cycles.
  - DATA: 8 bits, LSB first, each held DIV cycles. Bit index counts 0..7.
  - STOP: tx=1 for DIV cycles. tx_done pulses in the final STOP cycle.
    - If empty=0 in that cycle, the next byte is popped and the FSM goes directly to START (no idle gap).
    - Otherwise the FSM goes to IDLE.
- Latency: wr_en sampled at edge k into an idle, empty block -> tx low after edge k+1. Frame length is exactly 10*DIV cycles.
- Baud counter: counts 0..DIV-1 and reloads on each bit boundary. Width is sized for the 9600 divisor. Divisors are computed at elaboration from CLK_FREQ.
- Baud_Set changes take effect only at the next frame start; the in-flight frame keeps its latched rate.
- full/empty/level are registered and reflect the state after the current edge. A pop and a push in the same edge keep level constant.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - Adds input parity_odd (1 bit, latched at frame start alongside Baud_Set).
  - Inserts a PARITY state between DATA and STOP: one DIV-cycle bit equal to the XOR of the 8 data bits (even parity), inverted when parity_odd=1.
  - Frame length becomes 11*DIV.
- When undefined: no parity_odd port, no PARITY state, frame is 10*DIV (pure 8N1).

Test Plan:
- CLK_FREQ=1_152_000, Baud_Set=4 (DIV=10); push 0xA5 once -> tx low after 1 cycle, then bit pattern 0,1,0,1,0,0,1,0,1,1 each 10 cycles; tx_done pulse at cycle 100 of frame; tx_busy low afterward; empty=1.
- Push 3 bytes 0x01,0x80,0xFF on consecutive cycles -> level peaks at 2 (one popped immediately); three frames with no idle gap (30 bit periods = 300 cycles contiguous); three tx_done pulses spaced 100 cycles.
- Push 17 bytes 0x00..0x10 on consecutive cycles while the first frame is in flight -> full asserts; overflow pulses exactly once, for 0x10; all 16 accepted bytes transmitted in order.
- Baud_Set=0 (DIV=120): push 0x55; change Baud_Set to 4 at cycle 300 mid-frame -> frame keeps 120-cycle bits; a second byte pushed later uses 10-cycle bits.
- Push 0xC3, then assert rst_n=0 for one edge during DATA bit 3 -> tx=1 next cycle, level=0, empty=1, no tx_done; a subsequent push of 0x3C transmits a clean frame.
- With UART_TX_PARITY_EN and parity_odd=0: push 0x07 -> parity bit 1, stop bit at bit slot 10, frame 110 cycles. With parity_odd=1 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Byte-push and serial-status bundle for uart_tx_fifo.
// Define UART_TX_PARITY_EN to add the parity_odd select.
interface uart_tx_fifo_if #(
    parameter int unsigned ADDR_W = 4
);
    logic [2:0]      Baud_Set;
    logic            wr_en;
    logic [7:0]      wr_data;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] level;
    logic            overflow;
    logic            tx;
    logic            tx_busy;
    logic            tx_done;
`ifdef UART_TX_PARITY_EN
    logic            parity_odd;

    modport master (
        output Baud_Set, wr_en, wr_data, parity_odd,
        input  full, empty, level, overflow, tx, tx_busy, tx_done
    );
    modport slave (
        input  Baud_Set, wr_en, wr_data, parity_odd,
        output full, empty, level, overflow, tx, tx_busy, tx_done
    );
`else
    modport master (
        output Baud_Set, wr_en, wr_data,
        input  full, empty, level, overflow, tx, tx_busy, tx_done
    );
    modport slave (
        input  Baud_Set, wr_en, wr_data,
        output full, empty, level, overflow, tx, tx_busy, tx_done
    );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: DEPTH-entry FIFO drained back-to-back onto tx.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd via parity_odd).
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  bus
);

    localparam int unsigned DIV_9600   = CLK_FREQ / 9600;
    localparam int unsigned DIV_19200  = CLK_FREQ / 19200;
    localparam int unsigned DIV_38400  = CLK_FREQ / 38400;
    localparam int unsigned DIV_57600  = CLK_FREQ / 57600;
    localparam int unsigned DIV_115200 = CLK_FREQ / 115200;
    localparam int unsigned CNT_W      = (DIV_9600 > 1) ? $clog2(DIV_9600) : 1;

    localparam logic [CNT_W-1:0] M1_9600   = CNT_W'(DIV_9600 - 1);
    localparam logic [CNT_W-1:0] M1_19200  = CNT_W'(DIV_19200 - 1);
    localparam logic [CNT_W-1:0] M1_38400  = CNT_W'(DIV_38400 - 1);
    localparam logic [CNT_W-1:0] M1_57600  = CNT_W'(DIV_57600 - 1);
    localparam logic [CNT_W-1:0] M1_115200 = CNT_W'(DIV_115200 - 1);
    localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        mem_q [DEPTH];

    logic              full, empty, push, pop, bit_end, tx_done, tx;
    logic [CNT_W-1:0]  sel_div;
    logic [7:0]        head;

    assign full  = (level_q == DEPTH_L);
    assign empty = (level_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        sel_div = M1_115200;
        case (bus.Baud_Set)
            3'd0:    sel_div = M1_9600;
            3'd1:    sel_div = M1_19200;
            3'd2:    sel_div = M1_38400;
            3'd3:    sel_div = M1_57600;
            default: sel_div = M1_115200;
        endcase
    end

    // Frame sequencer; a pop always coincides with loading a new frame.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        pop     = 1'b0;
        tx_done = 1'b0;
        tx      = 1'b1;
        bit_end = (cnt_q == div_q);
        if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                tx = shift_q[0];
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (bit_q == 3'd7) state_d = PARITY;
`else
                    if (bit_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx = par_q;
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    tx_done = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            shift_d = head;
            div_d   = sel_div;
`ifdef UART_TX_PARITY_EN
            par_d   = (^head) ^ bus.parity_odd;
`endif
        end
    end

    // A push into a full FIFO is still taken when the sequencer pops that edge.
    always_comb begin
        push     = bus.wr_en && (!full || pop);
        ovf_d    = bus.wr_en && full && !pop;
        wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
            2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= M1_115200;
            bit_q    <= '0;
            shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.level    = level_q;
    assign bus.overflow = ovf_q;
    assign bus.tx       = tx;
    assign bus.tx_busy  = (state_q != IDLE);
    assign bus.tx_done  = tx_done;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLK_FREQ=1_152_000 (DIV=10 at 115200, 120 at 9600).
module tb_uart_tx_fifo;

    localparam int unsigned CLK_FREQ = 1_152_000;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned ADDR_W   = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FR = 11;
`else
    localparam int FR = 10;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

    uart_tx_fifo #(
        .CLK_FREQ(CLK_FREQ),
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int          checks  = 0;
    int          errors  = 0;
    int unsigned cyc     = 0;
    int          ovf_cnt = 0;
    int          stop_bad = 0;
    int          lvl_max = 0;
    int          mon_div = 10;
    bit          mon_en  = 1'b1;
    logic [7:0]  rx_q[$];
    int unsigned done_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.tx_done === 1'b1) done_q.push_back(cyc);
        if (bus.overflow === 1'b1) ovf_cnt++;
        if (int'(bus.level) > lvl_max) lvl_max = int'(bus.level);
    end

    // Independent serial receiver: mid-bit sampling from the start-bit edge.
    initial begin : rx_mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && bus.tx === 1'b0) begin
                repeat (mon_div / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_div) @(negedge clk);
                    b[i] = bus.tx;
                end
                repeat (mon_div * (FR - 9)) @(negedge clk);
                if (bus.tx !== 1'b1) stop_bad++;
                rx_q.push_back(b);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(logic [7:0] b);
        bus.wr_data = b;
        bus.wr_en   = 1'b1;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_done(int n, int budget);
        int t = 0;
        while (done_q.size() < n && t < budget) begin
            step();
            t++;
        end
        chk("done_timeout", 32'(done_q.size() >= n), 32'd1);
    endtask

    task automatic clear_mon();
        rx_q.delete();
        done_q.delete();
    endtask

    function automatic logic [31:0] rx_at(int i);
        return (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] done_at(int i);
        return (i < done_q.size()) ? 32'(done_q[i]) : 32'hDEAD;
    endfunction

    initial begin : stim
        logic [9:0]  pat;
        int unsigned s;
        logic [7:0]  bseq [3];
        bseq = '{8'h01, 8'h80, 8'hFF};

        bus.wr_en    = 1'b0;
        bus.wr_data  = 8'h00;
        bus.Baud_Set = 3'd4;
`ifdef UART_TX_PARITY_EN
        bus.parity_odd = 1'b0;
`endif
        rst_n = 1'b0;
        step(2);
        chk("rst_tx", 32'(bus.tx), 32'd1);
        chk("rst_busy", 32'(bus.tx_busy), 32'd0);
        chk("rst_done", 32'(bus.tx_done), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_level", 32'(bus.level), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Single 0xA5 frame, bit-by-bit at mid-bit
        clear_mon();
        push(8'hA5);
        chk("t1_level_after_push", 32'(bus.level), 32'd1);
        chk("t1_tx_idle", 32'(bus.tx), 32'd1);
        step();
        s = cyc;
        chk("t1_tx_start", 32'(bus.tx), 32'd0);
        chk("t1_busy", 32'(bus.tx_busy), 32'd1);
        chk("t1_level_popped", 32'(bus.level), 32'd0);
        pat = {1'b1, 8'hA5, 1'b0};
        step(5);
        for (int j = 0; j < 10; j++) begin
            chk($sformatf("t1_bit%0d", j), 32'(bus.tx), 32'(pat[j]));
            step(10);
        end
`ifndef UART_TX_PARITY_EN
        chk("t1_done_cnt", 32'(done_q.size()), 32'd1);
        chk("t1_done_cyc", done_at(0), 32'(s + 99));
        chk("t1_busy_after", 32'(bus.tx_busy), 32'd0);
        chk("t1_empty", 32'(bus.empty), 32'd1);
`endif
        step(20);

        // Three back-to-back frames
        clear_mon();
        lvl_max = 0;
        bus.wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_data = bseq[i];
            step();
        end
        bus.wr_en = 1'b0;
        wait_done(3, 40 * FR);
        step(2);
        chk("t2_level_peak", 32'(lvl_max), 32'd2);
        chk("t2_rx_cnt", 32'(rx_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk($sformatf("t2_rx%0d", i), rx_at(i), 32'(bseq[i]));
        chk("t2_gap01", done_at(1) - done_at(0), 32'(10 * FR));
        chk("t2_gap12", done_at(2) - done_at(1), 32'(10 * FR));
        chk("t2_busy_after", 32'(bus.tx_busy), 32'd0);
        chk("t2_empty", 32'(bus.empty), 32'd1);
        step(20);

        // Fill past DEPTH while a frame is in flight
        clear_mon();
        ovf_cnt = 0;
        push(8'hEE);
        step(3);
        bus.wr_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.wr_data = 8'(i);
            step();
            if (i == 14) chk("t3_not_full_15", 32'(bus.full), 32'd0);
            if (i == 15) begin
                chk("t3_full", 32'(bus.full), 32'd1);
                chk("t3_level16", 32'(bus.level), 32'd16);
                chk("t3_no_ovf_yet", 32'(bus.overflow), 32'd0);
            end
            if (i == 16) begin
                chk("t3_ovf_pulse", 32'(bus.overflow), 32'd1);
                chk("t3_level_held", 32'(bus.level), 32'd16);
            end
        end
        bus.wr_en = 1'b0;
        step();
        chk("t3_ovf_one_cycle", 32'(bus.overflow), 32'd0);
        wait_done(17, 18 * 10 * FR);
        step(2);
        chk("t3_ovf_cnt", 32'(ovf_cnt), 32'd1);
        chk("t3_rx_cnt", 32'(rx_q.size()), 32'd17);
        chk("t3_rx_first", rx_at(0), 32'hEE);
        for (int i = 0; i < 16; i++) chk($sformatf("t3_rx%0d", i + 1), rx_at(i + 1), 32'(i));
        chk("t3_empty", 32'(bus.empty), 32'd1);
        step(20);

        // Baud change mid-frame only affects the next frame
        clear_mon();
        bus.Baud_Set = 3'd0;
        mon_div = 120;
        push(8'h55);
        step();
        s = cyc;
        step(299);
        bus.Baud_Set = 3'd4;
        wait_done(1, 130 * FR);
        chk("t4_slow_done_cyc", done_at(0), 32'(s + 120 * FR - 1));
        chk("t4_slow_rx", rx_at(0), 32'h55);
        step(5);
        clear_mon();
        mon_div = 10;
        push(8'hA3);
        step();
        s = cyc;
        wait_done(1, 20 * FR);
        step(2);
        chk("t4_fast_done_cyc", done_at(0), 32'(s + 10 * FR - 1));
        chk("t4_fast_rx", rx_at(0), 32'hA3);
        step(20);

        // Reset during DATA bit 3 aborts the frame and flushes the FIFO
        mon_en = 1'b0;
        step(2);
        clear_mon();
        push(8'hC3);
        push(8'h99);
        step(44);
        chk("t5_bit3_before_rst", 32'(bus.tx), 32'd0);
        chk("t5_level_before_rst", 32'(bus.level), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_tx_high", 32'(bus.tx), 32'd1);
        chk("t5_busy", 32'(bus.tx_busy), 32'd0);
        chk("t5_level", 32'(bus.level), 32'd0);
        chk("t5_empty", 32'(bus.empty), 32'd1);
        step(150);
        chk("t5_no_done", 32'(done_q.size()), 32'd0);
        chk("t5_tx_still_high", 32'(bus.tx), 32'd1);
        mon_en = 1'b1;
        step(2);
        push(8'h3C);
        wait_done(1, 20 * FR);
        step(2);
        chk("t5_clean_rx", rx_at(0), 32'h3C);
        chk("t5_stop_bits", 32'(stop_bad), 32'd0);

`ifdef UART_TX_PARITY_EN
        // Parity slot (bit 9) and stop slot (bit 10) for 0x07
        mon_en = 1'b0;
        step(20);
        for (int p = 0; p < 2; p++) begin
            clear_mon();
            bus.parity_odd = p[0];
            push(8'h07);
            step();
            s = cyc;
            step(95);
            chk($sformatf("tp_parity_odd%0d", p), 32'(bus.tx), 32'(~p[0]));
            step(10);
            chk($sformatf("tp_stop_odd%0d", p), 32'(bus.tx), 32'd1);
            wait_done(1, 50);
            chk($sformatf("tp_done_cyc%0d", p), done_at(0), 32'(s + 109));
            step(10);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
